// File: rtl/serial_tx_if.sv
// Parallel-load / serial-out bus for serial_tx.
// The master drives load/data and receives the serial line and status flags.
interface serial_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic             s;
    logic             busy;
    logic             done;

    modport master (
        output load,
        output data,
        input  s,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  data,
        output s,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_tx.sv
// Start/data(LSB first)/stop serial transmitter with DIV clocks per bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module serial_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input logic         clk,
    input logic         clear,
    serial_tx_if.slave  bus
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] DivLast = CntW'(DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;
`endif

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_shift, w_shift_d;
    logic [BitW-1:0]  r_bit_cnt, w_bit_cnt_d;
    logic [CntW-1:0]  r_div_cnt, w_div_cnt_d;
    logic             r_s, w_s_d;
    logic             r_busy, w_busy_d;
    logic             r_done, w_done_d;
    logic             w_tick;
`ifdef SERIAL_TX_PARITY_EN
    logic             r_par, w_par_d;
`endif

    // Bit boundary: the period counter reloads instead of wrapping, so DIV=1 is safe.
    assign w_tick = (r_div_cnt == '0);

    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_bit_cnt_d = r_bit_cnt;
        w_div_cnt_d = r_div_cnt;
        w_s_d       = r_s;
        w_done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        w_par_d     = r_par;
`endif

        unique case (r_state)
            StIdle: begin
                if (bus.load) begin
                    w_state_d   = StStart;
                    w_shift_d   = bus.data;
                    w_bit_cnt_d = '0;
                    w_div_cnt_d = DivLast;
                    w_s_d       = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                    w_par_d     = ^bus.data;
`endif
                end
            end
            StStart: begin
                if (w_tick) begin
                    w_state_d   = StData;
                    w_div_cnt_d = DivLast;
                    w_s_d       = r_shift[0];
                end else begin
                    w_div_cnt_d = r_div_cnt - 1'b1;
                end
            end
            StData: begin
                if (w_tick) begin
                    w_div_cnt_d = DivLast;
                    if (r_bit_cnt == BitLast) begin
`ifdef SERIAL_TX_PARITY_EN
                        w_state_d = StParity;
                        w_s_d     = r_par;
`else
                        w_state_d = StStop;
                        w_s_d     = 1'b1;
`endif
                    end else begin
                        w_shift_d   = r_shift >> 1;
                        w_bit_cnt_d = r_bit_cnt + 1'b1;
                        w_s_d       = w_shift_d[0];
                    end
                end else begin
                    w_div_cnt_d = r_div_cnt - 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (w_tick) begin
                    w_state_d   = StStop;
                    w_div_cnt_d = DivLast;
                    w_s_d       = 1'b1;
                end else begin
                    w_div_cnt_d = r_div_cnt - 1'b1;
                end
            end
`endif
            StStop: begin
                if (w_tick) begin
                    w_state_d   = StIdle;
                    w_div_cnt_d = '0;
                    w_s_d       = 1'b1;
                    w_done_d    = 1'b1;
                end else begin
                    w_div_cnt_d = r_div_cnt - 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_s_d     = 1'b1;
            end
        endcase

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_s       <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_div_cnt <= w_div_cnt_d;
            r_s       <= w_s_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
`ifdef SERIAL_TX_PARITY_EN
            r_par     <= w_par_d;
`endif
        end
    end

    assign bus.s    = r_s;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: reset, frames, ignored/back-to-back load, abort, DIV=1.
// Expectations follow SERIAL_TX_PARITY_EN when it is defined.
module tb_serial_tx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIV   = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = WIDTH + 3;
`else
    localparam int NBITS = WIDTH + 2;
`endif

    logic clk   = 1'b0;
    logic clear = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    serial_tx_if #(.WIDTH(WIDTH)) bus ();
    serial_tx_if #(.WIDTH(4))     bus_min ();

    serial_tx #(.WIDTH(WIDTH), .DIV(DIV)) u_dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    serial_tx #(.WIDTH(4), .DIV(1)) u_dut_min (
        .clk   (clk),
        .clear (clear),
        .bus   (bus_min.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends d and checks every cycle of the frame; ignore_at >= 0 pulses a stray load then.
    task automatic send_frame(input logic [7:0] d, input int ignore_at, input string tag,
                              input bit chain);
        logic exp_bits[NBITS];
        int   cyc;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) exp_bits[i+1] = d[i];
`ifdef SERIAL_TX_PARITY_EN
        exp_bits[WIDTH+1] = ^d;
`endif
        exp_bits[NBITS-1] = 1'b1;

        bus.load = 1'b1;
        bus.data = d;
        step();
        bus.load = 1'b0;
        bus.data = ~d;
        cyc = 0;
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < DIV; c++) begin
                chk($sformatf("%s s bit%0d c%0d", tag, k, c), 32'(bus.s), 32'(exp_bits[k]));
                chk($sformatf("%s busy bit%0d c%0d", tag, k, c), 32'(bus.busy), 32'd1);
                chk($sformatf("%s done bit%0d c%0d", tag, k, c), 32'(bus.done), 32'd0);
                if (cyc == ignore_at) begin
                    bus.load = 1'b1;
                    bus.data = 8'h00;
                end else begin
                    bus.load = 1'b0;
                end
                cyc++;
                step();
            end
        end
        chk({tag, " end s"}, 32'(bus.s), 32'd1);
        chk({tag, " end busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " end done"}, 32'(bus.done), 32'd1);
        if (!chain) begin
            step();
            chk({tag, " idle done"}, 32'(bus.done), 32'd0);
            chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
            chk({tag, " idle s"}, 32'(bus.s), 32'd1);
        end
    endtask

    initial begin
        logic min_exp[6];

        bus.load     = 1'b0;
        bus.data     = '0;
        bus_min.load = 1'b0;
        bus_min.data = '0;

        // Reset before any clock edge
        #1 clear = 1'b1;
        #1;
        chk("rst s", 32'(bus.s), 32'd1);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst min s", 32'(bus_min.s), 32'd1);
        step();
        chk("rst held s", 32'(bus.s), 32'd1);
        chk("rst held busy", 32'(bus.busy), 32'd0);
        clear = 1'b0;
        step();
        chk("idle s", 32'(bus.s), 32'd1);
        chk("idle done", 32'(bus.done), 32'd0);

        send_frame(8'hA5, -1, "a5", 1'b0);
        send_frame(8'h07, -1, "07", 1'b0);

        // Stray load mid-frame, then a back-to-back load in the done cycle
        send_frame(8'h5A, 13, "ign", 1'b1);
        send_frame(8'h3C, -1, "b2b", 1'b0);

        // Abort during DATA bit 3 (edges 16..19 after the load edge)
        bus.load = 1'b1;
        bus.data = 8'hA5;
        step();
        bus.load = 1'b0;
        repeat (17) step();
        chk("abort pre s", 32'(bus.s), 32'd0);
        chk("abort pre busy", 32'(bus.busy), 32'd1);
        clear = 1'b1;
        #1;
        chk("abort s", 32'(bus.s), 32'd1);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        step();
        chk("abort held done", 32'(bus.done), 32'd0);
        clear = 1'b0;
        chk("abort rel s", 32'(bus.s), 32'd1);
        send_frame(8'hFF, -1, "ff", 1'b0);

        // DIV=1, WIDTH=4, data 1001
        min_exp[0] = 1'b0;
        min_exp[1] = 1'b1;
        min_exp[2] = 1'b0;
        min_exp[3] = 1'b0;
        min_exp[4] = 1'b1;
        min_exp[5] = 1'b1;
        bus_min.load = 1'b1;
        bus_min.data = 4'b1001;
        step();
        bus_min.load = 1'b0;
        bus_min.data = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("min s %0d", i), 32'(bus_min.s), 32'(min_exp[i]));
            chk($sformatf("min busy %0d", i), 32'(bus_min.busy), 32'd1);
            chk($sformatf("min done %0d", i), 32'(bus_min.done), 32'd0);
            step();
        end
        chk("min end done", 32'(bus_min.done), 32'd1);
        chk("min end busy", 32'(bus_min.busy), 32'd0);
        chk("min end s", 32'(bus_min.s), 32'd1);
        step();
        chk("min idle done", 32'(bus_min.done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the number of data bits per frame (legal range 1..32).
REQ-002 The module SHALL have parameter DIV, default 4, the clock cycles per serial bit period (legal range 1..256).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on posedge clk.
REQ-004 The module SHALL have port clear, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-005 The module SHALL have port load, input, 1 bit, a request to transmit data; it is sampled only in IDLE.
REQ-006 The module SHALL have port data, input, WIDTH bits, the parallel word to transmit, captured on an accepted load.
REQ-007 The module SHALL have port s, output, 1 bit, the registered serial line; it idles high.
REQ-008 The module SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-009 The module SHALL have port done, output, 1 bit, a one-cycle pulse at frame completion.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY (present only when the macro is defined) and STOP.
REQ-011 In IDLE, load=1 at a rising edge SHALL capture data into the shift register, enter START, and drive s=0 from that edge.
REQ-012 Each of START, each DATA bit, PARITY and STOP SHALL last exactly DIV cycles, timed by a bit-period counter that reloads on every bit boundary.
REQ-013 DATA SHALL transmit the word LSB first; the register SHALL shift right once per bit period; s SHALL equal register bit 0.
REQ-014 A bit counter SHALL leave DATA after exactly WIDTH bit periods, going to PARITY if enabled, otherwise to STOP.
REQ-015 STOP SHALL drive s=1 for DIV cycles, then return to IDLE.
REQ-016 Frame length SHALL be (WIDTH+2)*DIV cycles without parity and (WIDTH+3)*DIV cycles with parity, measured from the load edge to the IDLE entry edge.
REQ-017 busy SHALL be 1 in every state except IDLE, and SHALL be registered and aligned with s.
REQ-018 done SHALL be 1 for exactly the first clock cycle after returning to IDLE, and 0 otherwise.
REQ-019 A load in the cycle where done=1 SHALL be accepted, giving back-to-back frames with no idle gap beyond that cycle.
REQ-020 A load while busy=1 SHALL be ignored, with no queuing; data changes while busy SHALL NOT affect the frame.
REQ-021 When DIV=1, every bit SHALL last one cycle, and the counter logic SHALL NOT underflow or wrap.

Reset
REQ-022 While clear=1, regardless of clk, the module SHALL set state=IDLE, s=1, busy=0, done=0, and clear the shift register, bit counter and bit-period counter.
REQ-023 Asserting clear mid-frame SHALL abort the frame immediately, and no done pulse SHALL be generated.
REQ-024 After clear deasserts, the first load SHALL be accepted at the next rising edge.

Configuration
REQ-025 With macro SERIAL_TX_PARITY_EN defined, the module SHALL insert one PARITY bit after DATA, equal to the XOR of the captured word (even parity), lasting DIV cycles.
REQ-026 Without SERIAL_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-027 Reset check: with WIDTH=8 and DIV=4, assert clear -> s=1, busy=0, done=0 immediately, before any clk edge.
REQ-028 Basic frame, no parity: WIDTH=8, DIV=4, load data=8'hA5 -> s gives 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy=1 for 40 cycles; done pulses in cycle 41.
REQ-029 Parity frame: SERIAL_TX_PARITY_EN defined, data=8'hA5 -> parity bit 0 after bit 7, 44-cycle frame; data=8'h07 -> parity bit 1.
REQ-030 Ignored and back-to-back load: load pulsed mid-frame -> no effect; load=1 with data=8'h3C in the done cycle -> a start bit begins at the next edge, frame correct.
REQ-031 Abort: clear asserted during DATA bit 3 -> s=1 and busy=0 at once, with no done; a following load of 8'hFF sends a complete, correct frame.
REQ-032 Minimum divider: DIV=1, WIDTH=4, data=4'b1001 -> s gives 0,1,0,0,1,1 on consecutive cycles; done follows 6 cycles after load.
